// File: rtl/audioport_pkg.sv
// Shared types and constants for the audio output path.
package audioport_pkg;

    localparam int PLAY_HOLD_CYCLES = 384;
    localparam int SMP_W = 24;

    typedef enum logic [2:0] {
        ST_STANDBY,
        ST_CFG,
        ST_START_HOLD,
        ST_PLAY,
        ST_STOP_HOLD
    } seq_state_t;

endpackage

// File: rtl/i2s_play_sequencer_if.sv
// Command, sample handshake and I2S drive bundle of the play sequencer.
interface i2s_play_sequencer_if;
    import audioport_pkg::*;

    logic             start_in;
    logic             stop_in;
    logic             cfg_cmd_in;
    logic [31:0]      cfg_data_in;
    logic             smp_valid_in;
    logic             smp_ready_out;
    logic [SMP_W-1:0] smp0_in;
    logic [SMP_W-1:0] smp1_in;
    logic             req_in;
    logic             play_out;
    logic             cfg_out;
    logic [31:0]      cfg_reg_out;
    logic             tick_out;
    logic [SMP_W-1:0] audio0_out;
    logic [SMP_W-1:0] audio1_out;
    logic             underrun_out;
    logic             busy_out;

    modport master (
        input  start_in, stop_in, cfg_cmd_in, cfg_data_in,
        input  smp_valid_in, smp0_in, smp1_in, req_in,
        output smp_ready_out, play_out, cfg_out, cfg_reg_out,
        output tick_out, audio0_out, audio1_out,
        output underrun_out, busy_out
    );

    modport slave (
        output start_in, stop_in, cfg_cmd_in, cfg_data_in,
        output smp_valid_in, smp0_in, smp1_in, req_in,
        input  smp_ready_out, play_out, cfg_out, cfg_reg_out,
        input  tick_out, audio0_out, audio1_out,
        input  underrun_out, busy_out
    );

endinterface

// File: rtl/i2s_sample_buf.sv
// Two-entry stereo sample FIFO with synchronous flush.
module i2s_sample_buf
    import audioport_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_in,
    input  logic               pop_in,
    input  logic               flush_in,
    input  logic [2*SMP_W-1:0] data_in,
    output logic [2*SMP_W-1:0] data_out,
    output logic               full_out,
    output logic               empty_out
);

    logic [2*SMP_W-1:0] mem_q [2];
    logic [2*SMP_W-1:0] mem_d [2];
    logic rd_ptr_q, rd_ptr_d;
    logic wr_ptr_q, wr_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign empty_out = (cnt_q == 2'd0);
    assign full_out  = (cnt_q == 2'd2);
    assign data_out  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop_in && !empty_out;
        // A pop frees the slot, so a full buffer may push in the same cycle
        do_push  = push_in && (!full_out || do_pop);
        if (flush_in) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d = !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/i2s_play_sequencer.sv
// Sequences play/cfg control of the I2S unit and feeds it buffered samples.
module i2s_play_sequencer
    import audioport_pkg::*;
#(
    parameter int PLAY_HOLD = PLAY_HOLD_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    i2s_play_sequencer_if.master bus
);

    localparam int CW = $clog2(PLAY_HOLD);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(PLAY_HOLD - 1);

    seq_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic play_q, play_d;
    logic cfg_q, cfg_d;
    logic [31:0] cfg_reg_q, cfg_reg_d;
    logic [31:0] cfg_pdata_q, cfg_pdata_d;
    logic tick_q, tick_d;
    logic [SMP_W-1:0] audio0_q, audio0_d;
    logic [SMP_W-1:0] audio1_q, audio1_d;
    logic underrun_q, underrun_d;
    logic stop_pend_q, stop_pend_d;
    logic start_pend_q, start_pend_d;
    logic cfg_pend_q, cfg_pend_d;

    logic buf_push, buf_pop, buf_flush;
    logic buf_full, buf_empty;
    logic [2*SMP_W-1:0] buf_rdata;

    assign bus.smp_ready_out = play_q && !buf_full;
    assign buf_push = bus.smp_valid_in && bus.smp_ready_out;

    i2s_sample_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push_in   (buf_push),
        .pop_in    (buf_pop),
        .flush_in  (buf_flush),
        .data_in   ({bus.smp0_in, bus.smp1_in}),
        .data_out  (buf_rdata),
        .full_out  (buf_full),
        .empty_out (buf_empty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        play_d       = play_q;
        cfg_d        = 1'b0;
        cfg_reg_d    = cfg_reg_q;
        cfg_pdata_d  = cfg_pdata_q;
        tick_d       = 1'b0;
        audio0_d     = audio0_q;
        audio1_d     = audio1_q;
        underrun_d   = underrun_q;
        stop_pend_d  = stop_pend_q;
        start_pend_d = start_pend_q;
        cfg_pend_d   = cfg_pend_q;
        buf_pop      = 1'b0;
        buf_flush    = 1'b0;
        unique case (state_q)
            ST_STANDBY: begin
                if (bus.cfg_cmd_in || cfg_pend_q) begin
                    state_d    = ST_CFG;
                    cfg_d      = 1'b1;
                    cfg_pend_d = 1'b0;
                    cfg_reg_d  = bus.cfg_cmd_in ? bus.cfg_data_in
                                                : cfg_pdata_q;
                    if (bus.start_in) start_pend_d = 1'b1;
                end else if (bus.start_in || start_pend_q) begin
                    state_d      = ST_START_HOLD;
                    play_d       = 1'b1;
                    cnt_d        = HOLD_LOAD;
                    start_pend_d = 1'b0;
                    stop_pend_d  = 1'b0;
                    underrun_d   = 1'b0;
                end
            end
            ST_CFG: begin
                state_d = ST_STANDBY;
                if (bus.start_in) start_pend_d = 1'b1;
            end
            ST_START_HOLD: begin
                if (bus.stop_in) stop_pend_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (stop_pend_q || bus.stop_in) begin
                    // Hold already satisfied: drop play without a PLAY cycle
                    state_d     = ST_STOP_HOLD;
                    play_d      = 1'b0;
                    cnt_d       = HOLD_LOAD;
                    stop_pend_d = 1'b0;
                    buf_flush   = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop_pend_q || bus.stop_in) begin
                    state_d     = ST_STOP_HOLD;
                    play_d      = 1'b0;
                    cnt_d       = HOLD_LOAD;
                    stop_pend_d = 1'b0;
                    buf_flush   = 1'b1;
                end else if (bus.req_in) begin
                    tick_d = 1'b1;
                    if (buf_empty) begin
                        audio0_d   = '0;
                        audio1_d   = '0;
                        underrun_d = 1'b1;
                    end else begin
                        audio0_d = buf_rdata[2*SMP_W-1:SMP_W];
                        audio1_d = buf_rdata[SMP_W-1:0];
                        buf_pop  = 1'b1;
                    end
                end
            end
            ST_STOP_HOLD: begin
                if (bus.start_in) start_pend_d = 1'b1;
                if (bus.cfg_cmd_in) begin
                    cfg_pend_d  = 1'b1;
                    cfg_pdata_d = bus.cfg_data_in;
                end
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else state_d = ST_STANDBY;
            end
            default: state_d = ST_STANDBY;
        endcase
        if (!play_d) begin
            audio0_d = '0;
            audio1_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_STANDBY;
            cnt_q        <= '0;
            play_q       <= 1'b0;
            cfg_q        <= 1'b0;
            cfg_reg_q    <= '0;
            cfg_pdata_q  <= '0;
            tick_q       <= 1'b0;
            audio0_q     <= '0;
            audio1_q     <= '0;
            underrun_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            start_pend_q <= 1'b0;
            cfg_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            play_q       <= play_d;
            cfg_q        <= cfg_d;
            cfg_reg_q    <= cfg_reg_d;
            cfg_pdata_q  <= cfg_pdata_d;
            tick_q       <= tick_d;
            audio0_q     <= audio0_d;
            audio1_q     <= audio1_d;
            underrun_q   <= underrun_d;
            stop_pend_q  <= stop_pend_d;
            start_pend_q <= start_pend_d;
            cfg_pend_q   <= cfg_pend_d;
        end
    end

    assign bus.play_out     = play_q;
    assign bus.cfg_out      = cfg_q;
    assign bus.cfg_reg_out  = cfg_reg_q;
    assign bus.tick_out     = tick_q;
    assign bus.audio0_out   = audio0_q;
    assign bus.audio1_out   = audio1_q;
    assign bus.underrun_out = underrun_q;
    assign bus.busy_out     = (state_q != ST_STANDBY);

endmodule

// File: tb/tb_i2s_play_sequencer.sv
// Directed vector bench for the I2S play sequencer.
module tb_i2s_play_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2s_play_sequencer_if bus();

    i2s_play_sequencer #(.PLAY_HOLD(384)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          pre;
        logic        st, sp, cf;
        logic [31:0] cd;
        logic        v;
        logic [23:0] s0, s1;
        logic        rq;
        logic        e_play, e_cfg, e_tick;
        logic [23:0] e_a0, e_a1;
        logic        e_und, e_busy, e_rdy;
        logic [31:0] e_reg;
        logic        reg_x;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(
        int pre, logic st, logic sp, logic cf, logic [31:0] cd,
        logic v, logic [23:0] s0, logic [23:0] s1, logic rq,
        logic ep, logic ec, logic et, logic [23:0] a0,
        logic [23:0] a1, logic eu, logic eb, logic er,
        logic [31:0] eg, logic gx);
        vec_t r;
        r.pre = pre; r.st = st; r.sp = sp; r.cf = cf; r.cd = cd;
        r.v = v; r.s0 = s0; r.s1 = s1; r.rq = rq;
        r.e_play = ep; r.e_cfg = ec; r.e_tick = et;
        r.e_a0 = a0; r.e_a1 = a1; r.e_und = eu;
        r.e_busy = eb; r.e_rdy = er; r.e_reg = eg; r.reg_x = gx;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle_in();
        bus.start_in = 0; bus.stop_in = 0; bus.cfg_cmd_in = 0;
        bus.cfg_data_in = 0; bus.smp_valid_in = 0;
        bus.smp0_in = 0; bus.smp1_in = 0; bus.req_in = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        idle_in();
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " play"}, {31'd0, bus.play_out}, 0);
        chk({nm, " cfg"}, {31'd0, bus.cfg_out}, 0);
        chk({nm, " reg"}, bus.cfg_reg_out, 0);
        chk({nm, " tick"}, {31'd0, bus.tick_out}, 0);
        chk({nm, " a0"}, {8'd0, bus.audio0_out}, 0);
        chk({nm, " a1"}, {8'd0, bus.audio1_out}, 0);
        chk({nm, " und"}, {31'd0, bus.underrun_out}, 0);
        chk({nm, " busy"}, {31'd0, bus.busy_out}, 0);
        chk({nm, " rdy"}, {31'd0, bus.smp_ready_out}, 0);
    endtask

    task automatic run_vec(input int i);
        vec_t x;
        string n;
        x = vecs[i];
        idle(x.pre);
        bus.start_in = x.st; bus.stop_in = x.sp;
        bus.cfg_cmd_in = x.cf; bus.cfg_data_in = x.cd;
        bus.smp_valid_in = x.v; bus.smp0_in = x.s0;
        bus.smp1_in = x.s1; bus.req_in = x.rq;
        cyc();
        idle_in();
        n = $sformatf("v%0d", i);
        chk({n, " play"}, {31'd0, bus.play_out}, {31'd0, x.e_play});
        chk({n, " cfg"}, {31'd0, bus.cfg_out}, {31'd0, x.e_cfg});
        chk({n, " tick"}, {31'd0, bus.tick_out}, {31'd0, x.e_tick});
        chk({n, " a0"}, {8'd0, bus.audio0_out}, {8'd0, x.e_a0});
        chk({n, " a1"}, {8'd0, bus.audio1_out}, {8'd0, x.e_a1});
        chk({n, " und"}, {31'd0, bus.underrun_out}, {31'd0, x.e_und});
        chk({n, " busy"}, {31'd0, bus.busy_out}, {31'd0, x.e_busy});
        chk({n, " rdy"}, {31'd0, bus.smp_ready_out}, {31'd0, x.e_rdy});
        if (!x.reg_x) chk({n, " reg"}, bus.cfg_reg_out, x.e_reg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fall_at, idle_at;
        // pre st sp cf cd  v s0 s1 rq | play cfg tick a0 a1 und busy rdy reg x
        vecs[0]  = mk(0,0,0,1,32'h2,0,0,0,0, 1'b0,1,0,0,0,0,1,0,32'h2,0);
        vecs[1]  = mk(0,0,0,0,0,0,0,0,0,     0,0,0,0,0,0,0,0,32'h2,0);
        vecs[2]  = mk(0,1,0,0,0,0,0,0,0,     1,0,0,0,0,0,1,1,32'h2,0);
        vecs[3]  = mk(0,0,0,0,0,1,24'h123456,24'hABCDEF,0,
                      1,0,0,0,0,0,1,1,32'h2,0);
        vecs[4]  = mk(0,0,0,0,0,1,24'h111111,24'h222222,0,
                      1,0,0,0,0,0,1,0,32'h2,0);
        vecs[5]  = mk(0,0,0,1,32'h55,0,0,0,0,1,0,0,0,0,0,1,0,32'h2,0);
        vecs[6]  = mk(0,0,0,0,0,0,0,0,1,     1,0,0,0,0,0,1,0,32'h2,0);
        vecs[7]  = mk(380,0,0,0,0,0,0,0,1,   1,0,1,24'h123456,24'hABCDEF,
                      0,1,1,32'h2,0);
        vecs[8]  = mk(0,0,0,0,0,1,24'h333333,24'h444444,1,
                      1,0,1,24'h111111,24'h222222,0,1,1,32'h2,0);
        vecs[9]  = mk(0,0,0,0,0,0,0,0,0,     1,0,0,24'h111111,24'h222222,
                      0,1,1,32'h2,0);
        vecs[10] = mk(0,0,0,0,0,0,0,0,1,     1,0,1,24'h333333,24'h444444,
                      0,1,1,32'h2,0);
        vecs[11] = mk(0,0,0,0,0,0,0,0,1,     1,0,1,0,0,1,1,1,32'h2,0);
        vecs[12] = mk(0,0,0,0,0,0,0,0,0,     1,0,0,0,0,1,1,1,32'h2,0);
        vecs[13] = mk(0,0,0,1,32'h77,0,0,0,0,1,0,0,0,0,1,1,1,32'h2,0);
        vecs[14] = mk(0,0,1,0,0,0,0,0,1,     0,0,0,0,0,1,1,0,32'h2,0);
        vecs[15] = mk(0,0,0,1,32'h9,0,0,0,0, 0,0,0,0,0,1,1,0,0,1);
        vecs[16] = mk(0,1,0,0,0,0,0,0,0,     0,0,0,0,0,1,1,0,0,1);
        vecs[17] = mk(381,0,0,0,0,0,0,0,0,   0,0,0,0,0,1,0,0,0,1);
        vecs[18] = mk(0,0,0,0,0,0,0,0,0,     0,1,0,0,0,1,1,0,32'h9,0);
        vecs[19] = mk(0,0,0,0,0,0,0,0,0,     0,0,0,0,0,1,0,0,32'h9,0);
        vecs[20] = mk(0,0,0,0,0,0,0,0,0,     1,0,0,0,0,0,1,1,32'h9,0);
        vecs[21] = mk(0,0,0,0,0,1,24'hA0A0A0,24'hB0B0B0,0,
                      1,0,0,0,0,0,1,1,32'h9,0);
        vecs[22] = mk(0,0,0,0,0,1,24'hC0C0C0,24'hD0D0D0,0,
                      1,0,0,0,0,0,1,0,32'h9,0);
        vecs[23] = mk(381,0,0,0,0,0,0,0,0,   1,0,0,0,0,0,1,0,32'h9,0);

        idle_in();
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();
        chk_all_zero("post_reset");

        for (int i = 0; i < 24; i++) run_vec(i);

        // Asynchronous reset while playing with two samples queued
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        cyc();
        rst = 1'b0;
        cyc();
        chk_all_zero("rst_release");

        bus.start_in = 1; cyc(); idle_in();
        chk("rs start play", {31'd0, bus.play_out}, 1);
        chk("rs empty rdy", {31'd0, bus.smp_ready_out}, 1);
        bus.smp_valid_in = 1;
        bus.smp0_in = 24'h0A0B0C; bus.smp1_in = 24'h0D0E0F;
        cyc();
        chk("rs push1 rdy", {31'd0, bus.smp_ready_out}, 1);
        bus.smp0_in = 24'h1A1B1C; bus.smp1_in = 24'h1D1E1F;
        cyc(); idle_in();
        chk("rs push2 rdy", {31'd0, bus.smp_ready_out}, 0);
        idle(382);
        bus.req_in = 1; cyc(); idle_in();
        chk("rs tick", {31'd0, bus.tick_out}, 1);
        chk("rs a0", {8'd0, bus.audio0_out}, 32'h0A0B0C);
        chk("rs a1", {8'd0, bus.audio1_out}, 32'h0D0E0F);

        bus.stop_in = 1; cyc(); idle_in();
        chk("stop play", {31'd0, bus.play_out}, 0);
        chk("stop a0", {8'd0, bus.audio0_out}, 0);
        idle_at = -1;
        for (int k = 0; k < 1000; k++) begin
            if (!bus.busy_out) begin
                idle_at = k;
                break;
            end
            cyc();
        end
        chk("stop reaches standby", {31'd0, idle_at >= 0}, 1);

        bus.stop_in = 1; cyc(); idle_in();
        chk("lone stop busy", {31'd0, bus.busy_out}, 0);
        chk("lone stop play", {31'd0, bus.play_out}, 0);

        // Start at edge 0, stop at edge 2: play high exactly one hold
        bus.start_in = 1; cyc(); idle_in();
        chk("ss rise", {31'd0, bus.play_out}, 1);
        fall_at = -1;
        idle_at = -1;
        for (int e = 1; e <= 800; e++) begin
            bus.stop_in = (e == 2);
            cyc();
            idle_in();
            if (!bus.play_out && fall_at < 0) fall_at = e;
            if (!bus.busy_out && idle_at < 0) begin
                idle_at = e;
                break;
            end
        end
        chk("ss fall edge", fall_at, 384);
        chk("ss standby edge", idle_at, 768);

        // cfg and start together: cfg served first, then start
        bus.cfg_cmd_in = 1; bus.cfg_data_in = 32'hC; bus.start_in = 1;
        cyc(); idle_in();
        chk("both cfg", {31'd0, bus.cfg_out}, 1);
        chk("both reg", bus.cfg_reg_out, 32'hC);
        chk("both play0", {31'd0, bus.play_out}, 0);
        cyc();
        chk("both cfg off", {31'd0, bus.cfg_out}, 0);
        chk("both play1", {31'd0, bus.play_out}, 0);
        cyc();
        chk("both play2", {31'd0, bus.play_out}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
